// File: rtl/halftone_pkg.sv
// Shared types, constants and arithmetic helpers for the halftone engine.
// HALFTONE_ROUND_EN selects round-half-up error terms; floor is the default.
package halftone_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRAY,
        ST_GFLUSH,
        ST_DRD,
        ST_DWR,
        ST_DONE
    } state_e;

    localparam int ERR_W  = 11;
    localparam int THRESH = 128;

    localparam int GW_R = 77;
    localparam int GW_G = 150;
    localparam int GW_B = 29;

    localparam int FS_RIGHT = 7;
    localparam int FS_DL    = 3;
    localparam int FS_DOWN  = 5;
    localparam int FS_DR    = 1;
    localparam int FS_SHIFT = 4;

    // Weights sum to 256, so the result always fits in 8 bits.
    function automatic logic [7:0] gray_of(input logic [23:0] rgb);
        logic [16:0] acc;
        acc = 17'(GW_R) * 17'(rgb[23:16])
            + 17'(GW_G) * 17'(rgb[15:8])
            + 17'(GW_B) * 17'(rgb[7:0])
            + 17'd128;
        return 8'(acc >> 8);
    endfunction

    function automatic logic signed [ERR_W-1:0] fs_term(
        input logic signed [ERR_W-1:0] e,
        input int                      k
    );
        logic signed [15:0] prod;
        prod = 16'(e) * 16'(k);
`ifdef HALFTONE_ROUND_EN
        prod = prod + 16'sd8;
`else
        prod = prod + 16'sd0;
`endif
        return ERR_W'(prod >>> FS_SHIFT);
    endfunction

endpackage

// File: rtl/halftone_engine_err_line_buf.sv
// Ping-pong pair of error line buffers: reads come from the current row bank,
// writes go to the next row bank, and swap_i exchanges their roles.
module err_line_buf #(
    parameter int DEPTH = 512,
    parameter int AW    = 9,
    parameter int ERR_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             swap_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [ERR_W-1:0] rd_data_o,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [ERR_W-1:0] wr_data_i
);

    logic sel_q;
    logic rd_sel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q    <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            if (swap_i)
                sel_q <= ~sel_q;
            if (rd_en_i)
                rd_sel_q <= sel_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic [ERR_W-1:0] mem [DEPTH];
            logic [ERR_W-1:0] rd_q;

            // Bank gi is "next" whenever it is not the selected (current) bank.
            always_ff @(posedge clk) begin
                if (wr_en_i && (sel_q != 1'(gi)))
                    mem[wr_addr_i] <= wr_data_i;
                if (rd_en_i)
                    rd_q <= mem[rd_addr_i];
            end
        end
    endgenerate

    assign rd_data_o = rd_sel_q ? g_bank[1].rd_q : g_bank[0].rd_q;

endmodule

// File: rtl/halftone_engine.sv
// Grayscale conversion from ROM to RAM, then in-place Floyd-Steinberg diffusion.
// Define HALFTONE_ROUND_EN for round-half-up error terms (default: floor).
module halftone_engine
    import halftone_pkg::*;
#(
    parameter int IMG_W  = 512,
    parameter int IMG_H  = 512,
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              gray_done,
    output logic              diff_done,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_data,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_idata,
    input  logic [7:0]        ram_odata
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [ADDR_W-1:0] LAST_P = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [XW-1:0]     LAST_X = XW'(IMG_W - 1);
    localparam logic [YW-1:0]     LAST_Y = YW'(IMG_H - 1);
    localparam logic signed [ERR_W-1:0] THRESH_V = ERR_W'(THRESH);
    localparam logic signed [ERR_W-1:0] WHITE_V  = ERR_W'(255);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] p_q, p_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic              gray_done_q, gray_done_d;
    logic              diff_done_q, diff_done_d;

    // s0/s1: partial next-row sums for x-1 and x; tail: next[IMG_W-1], kept
    // in a register so a row end never needs two line-buffer writes.
    logic signed [ERR_W-1:0] e_right_q, e_right_d;
    logic signed [ERR_W-1:0] s0_q, s0_d;
    logic signed [ERR_W-1:0] s1_q, s1_d;
    logic signed [ERR_W-1:0] tail_q, tail_d;

    logic                    lb_rd_en, lb_wr_en, lb_swap;
    logic [XW-1:0]           lb_wr_addr;
    logic [ERR_W-1:0]        lb_rd_data, lb_wr_data;

    logic [7:0]              gray_pix;
    logic signed [ERR_W-1:0] pix_s, e_below, v, err;
    logic signed [ERR_W-1:0] t7, t3, t5, t1;
    logic                    out_hi;

    assign gray_pix = gray_of(rom_data);

    assign pix_s   = $signed({{(ERR_W-8){1'b0}}, ram_odata});
    assign e_below = (y_q == '0)     ? '0 :
                     (x_q == LAST_X) ? tail_q : $signed(lb_rd_data);
    assign v       = pix_s + e_right_q + e_below;
    assign out_hi  = (v >= THRESH_V);
    assign err     = out_hi ? (v - WHITE_V) : v;

    assign t7 = fs_term(err, FS_RIGHT);
    assign t3 = fs_term(err, FS_DL);
    assign t5 = fs_term(err, FS_DOWN);
    assign t1 = fs_term(err, FS_DR);

    assign lb_wr_addr = x_q - XW'(1);
    assign lb_wr_data = s0_q + t3;

    assign busy      = (state_q != ST_IDLE);
    assign gray_done = gray_done_q;
    assign diff_done = diff_done_q;

    err_line_buf #(
        .DEPTH (IMG_W),
        .AW    (XW),
        .ERR_W (ERR_W)
    ) u_line_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .swap_i    (lb_swap),
        .rd_en_i   (lb_rd_en),
        .rd_addr_i (x_q),
        .rd_data_o (lb_rd_data),
        .wr_en_i   (lb_wr_en),
        .wr_addr_i (lb_wr_addr),
        .wr_data_i (lb_wr_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            p_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            gray_done_q <= 1'b0;
            diff_done_q <= 1'b0;
            e_right_q   <= '0;
            s0_q        <= '0;
            s1_q        <= '0;
            tail_q      <= '0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            x_q         <= x_d;
            y_q         <= y_d;
            gray_done_q <= gray_done_d;
            diff_done_q <= diff_done_d;
            e_right_q   <= e_right_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            tail_q      <= tail_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        x_d         = x_q;
        y_d         = y_q;
        gray_done_d = gray_done_q;
        diff_done_d = diff_done_q;
        e_right_d   = e_right_q;
        s0_d        = s0_q;
        s1_d        = s1_q;
        tail_d      = tail_q;
        rom_en      = 1'b0;
        rom_addr    = '0;
        ram_ren     = 1'b0;
        ram_wen     = 1'b0;
        ram_addr    = '0;
        ram_idata   = '0;
        lb_rd_en    = 1'b0;
        lb_wr_en    = 1'b0;
        lb_swap     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_GRAY;
                    p_d         = '0;
                    x_d         = '0;
                    y_d         = '0;
                    gray_done_d = 1'b0;
                    diff_done_d = 1'b0;
                    e_right_d   = '0;
                    s0_d        = '0;
                    s1_d        = '0;
                    tail_d      = '0;
                end
            end

            ST_GRAY: begin
                rom_en   = 1'b1;
                rom_addr = p_q;
                // rom_data now carries pixel p-1 from the previous request.
                if (p_q != '0) begin
                    ram_wen   = 1'b1;
                    ram_addr  = p_q - ADDR_W'(1);
                    ram_idata = gray_pix;
                end
                if (p_q == LAST_P) begin
                    state_d = ST_GFLUSH;
                end else begin
                    p_d = p_q + ADDR_W'(1);
                end
            end

            ST_GFLUSH: begin
                ram_wen     = 1'b1;
                ram_addr    = LAST_P;
                ram_idata   = gray_pix;
                gray_done_d = 1'b1;
                p_d         = '0;
                state_d     = ST_DRD;
            end

            ST_DRD: begin
                ram_ren  = 1'b1;
                ram_addr = p_q;
                lb_rd_en = 1'b1;
                state_d  = ST_DWR;
            end

            ST_DWR: begin
                ram_wen   = 1'b1;
                ram_addr  = p_q;
                ram_idata = out_hi ? 8'hFF : 8'h00;
                lb_wr_en  = (x_q != '0) && (y_q != LAST_Y);
                if (x_q == LAST_X) begin
                    tail_d    = s1_q + t5;
                    s0_d      = '0;
                    s1_d      = '0;
                    e_right_d = '0;
                end else begin
                    s0_d      = s1_q + t5;
                    s1_d      = t1;
                    e_right_d = t7;
                end
                if (p_q == LAST_P) begin
                    diff_done_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    state_d = ST_DRD;
                    p_d     = p_q + ADDR_W'(1);
                    if (x_q == LAST_X) begin
                        x_d     = '0;
                        y_d     = y_q + YW'(1);
                        lb_swap = 1'b1;
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_halftone_engine.sv
// Directed bench for halftone_engine on a 4x2 image with ROM/RAM models.
module tb_halftone_engine;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int AW = 3;
    localparam int N  = W * H;
`ifdef HALFTONE_ROUND_EN
    localparam int RND_P1 = 255;
`else
    localparam int RND_P1 = 0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, gray_done, diff_done;
    logic          rom_en, ram_ren, ram_wen;
    logic [AW-1:0] rom_addr, ram_addr;
    logic [23:0]   rom_data;
    logic [7:0]    ram_idata, ram_odata;

    logic [23:0]   rom_mem [N];
    logic [7:0]    ram_mem [N];

    int n_total     = 0;
    int n_bad       = 0;
    int overlap_cnt = 0;

    always #5 clk = ~clk;

    halftone_engine #(
        .IMG_W  (W),
        .IMG_H  (H),
        .ADDR_W (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .gray_done (gray_done),
        .diff_done (diff_done),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .ram_ren   (ram_ren),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_idata (ram_idata),
        .ram_odata (ram_odata)
    );

    always @(posedge clk) begin
        if (rom_en)  rom_data <= rom_mem[rom_addr];
        if (ram_wen) ram_mem[ram_addr] <= ram_idata;
        if (ram_ren) ram_odata <= ram_mem[ram_addr];
    end

    always @(negedge clk)
        if (ram_ren && ram_wen) overlap_cnt++;

    task automatic check_val(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic fill_gray(input logic [7:0] g);
        for (int p = 0; p < N; p++) rom_mem[p] = {g, g, g};
    endtask

    task automatic check_ram(input string tag, input int p, input int exp);
        check_val($sformatf("%s[%0d]", tag, p), int'(ram_mem[p]), exp);
    endtask

    // Pulses start and returns at the first negedge with gray_done high.
    task automatic run_gray(input bit poke);
        int k;
        int seq_err;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check_val("busy_after_start", int'(busy), 1);
        check_val("flags_cleared", int'({gray_done, diff_done}), 0);
        k = 0;
        seq_err = 0;
        while (!gray_done && k < N + 8) begin
            if (k < N && (!rom_en || rom_addr != AW'(k))) seq_err++;
            start = (poke && k == 3);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check_val("gray_cycles", k, N + 1);
        check_val("rom_seq_err", seq_err, 0);
    endtask

    task automatic wait_diff();
        int k;
        k = 0;
        while (!diff_done && k < 2 * N + 8) begin
            @(negedge clk);
            k++;
        end
        check_val("diff_cycles", k, 2 * N);
        check_val("busy_in_done", int'(busy), 1);
        @(negedge clk);
        check_val("busy_dropped", int'(busy), 0);
    endtask

    initial begin
        int exp_128 [N];
        int k;
        exp_128 = '{255, 0, 255, 0, 0, 255, 0, 255};

        repeat (2) @(negedge clk);
        check_val("reset_outs", int'({busy, gray_done, diff_done, rom_en, rom_addr,
                                      ram_ren, ram_wen, ram_addr, ram_idata}), 0);
        rst_n = 1'b1;

        // Gray formula on primaries, with a start poked mid-GRAY.
        fill_gray(8'd0);
        rom_mem[0] = {8'd255, 8'd0, 8'd0};
        rom_mem[1] = {8'd0, 8'd255, 8'd0};
        rom_mem[2] = {8'd0, 8'd0, 8'd255};
        rom_mem[3] = {8'd10, 8'd20, 8'd30};
        run_gray(1'b1);
        check_ram("gray_rgb", 0, 77);
        check_ram("gray_rgb", 1, 149);
        check_ram("gray_rgb", 2, 29);
        check_ram("gray_rgb", 3, 18);
        wait_diff();

        fill_gray(8'd255);
        run_gray(1'b0);
        wait_diff();
        for (int p = 0; p < N; p++) check_ram("white", p, 255);

        fill_gray(8'd0);
        run_gray(1'b0);
        wait_diff();
        for (int p = 0; p < N; p++) check_ram("black", p, 0);

        fill_gray(8'd0);
        rom_mem[0] = {8'd120, 8'd120, 8'd120};
        rom_mem[1] = {8'd75, 8'd75, 8'd75};
        run_gray(1'b0);
        wait_diff();
        check_ram("round", 0, 0);
        check_ram("round", 1, RND_P1);
        check_ram("round", 2, 0);
        check_ram("round", 3, 0);

        fill_gray(8'd128);
        run_gray(1'b0);
        wait_diff();
        for (int p = 0; p < N; p++) check_ram("mid128", p, exp_128[p]);

        // Reset while diffusion pixel 3 is being read.
        run_gray(1'b0);
        k = 0;
        while (!(ram_ren && ram_addr == AW'(3)) && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_val("reach_px3", int'(ram_ren && ram_addr == AW'(3)), 1);
        rst_n = 1'b0;
        #1;
        check_val("midrst_outs", int'({busy, gray_done, diff_done, rom_en, rom_addr,
                                       ram_ren, ram_wen, ram_addr, ram_idata}), 0);
        check_ram("partial", 2, 255);
        check_ram("partial", 3, 128);
        @(negedge clk) rst_n = 1'b1;

        run_gray(1'b0);
        wait_diff();
        for (int p = 0; p < N; p++) check_ram("rerun128", p, exp_128[p]);

        check_val("ren_wen_overlap", overlap_cnt, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
